// File: rtl/seq_mult_if.sv
// -----------------------------------------------------------------------------
// seq_mult_if
// Handshake and data bundle between a requester and the seq_mult multiplier.
//
// Valid/ready semantics: the requester raises `start` with `a`, `b` and
// `is_signed` valid in the same cycle. The request is taken on the rising edge
// where the unit is not busy (`busy`=0). While `busy`=1 any `start` is dropped
// and the operand lines are don't-care. `done` is a one-cycle pulse that marks
// the cycle in which `product` first shows the new result. `product` then
// holds until the next `done`.
//
// Signals:
//   start      requester -> unit  request a multiply
//   is_signed  requester -> unit  1 = two's-complement operands, 0 = unsigned
//   a, b       requester -> unit  multiplicand / multiplier, WIDTH bits each
//   busy       unit -> requester  operation in progress
//   done       unit -> requester  result-update pulse
//   product    unit -> requester  2*WIDTH-bit result
// -----------------------------------------------------------------------------
interface seq_mult_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, product
   );
endinterface : seq_mult_if

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
// Iterative shift-and-add multiplier. One multiplier bit is retired per clock
// through a single 2*WIDTH-bit adder. Signed operations are done on operand
// magnitudes; the sign is applied to the final sum.
//
// Parameters:
//   WIDTH      operand width (>= 2); the product is 2*WIDTH bits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        seq_mult_if slave modport (start/is_signed/a/b in,
//              busy/done/product out)
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Optional feature:
//   SEQ_MULT_EARLY_DONE_EN  when defined, the run ends as soon as the shifted
//                           multiplier becomes zero (at least one iteration).
//                           Results are unchanged; only latency shrinks.
// -----------------------------------------------------------------------------
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_mult_if.slave   bus,
   output logic [1:0]  dbg_state
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t           state_q,   state_d;
   logic [PW-1:0]    mcand_q,   mcand_d;
   logic [WIDTH-1:0] mplier_q,  mplier_d;
   logic [PW-1:0]    acc_q,     acc_d;
   logic             neg_q,     neg_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [PW-1:0]    product_q, product_d;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic             accept;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             neg_cap;
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] mplier_shift;
   logic             last_iter;
   logic             busy_o;
   logic             done_o;

   // A request is taken in IDLE and also in DONE, so a new operation can be
   // issued in the same cycle the previous result is announced.
   assign accept = bus.start && (state_q != S_RUN);

   // Operand magnitudes. Negating the most negative value wraps back to
   // 2^(WIDTH-1), which is exactly its magnitude when read as unsigned.
   always_comb begin : capture_c
      a_mag   = bus.a;
      b_mag   = bus.b;
      neg_cap = 1'b0;
      if (bus.is_signed) begin
         if (bus.a[WIDTH-1]) begin
            a_mag = -bus.a;
         end
         if (bus.b[WIDTH-1]) begin
            b_mag = -bus.b;
         end
         neg_cap = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end

   // One shift-and-add step.
   always_comb begin : step_c
      acc_next     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mplier_shift = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_DONE_EN
      // Once no set bits remain, further iterations cannot change the sum.
      // The counter bound is redundant but keeps the run bounded by WIDTH.
      last_iter    = (mplier_shift == '0) || (cnt_q == CW'(WIDTH - 1));
`else
      last_iter    = (cnt_q == CW'(WIDTH - 1));
`endif
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin : state_r
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin : next_state_c
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = accept ? S_RUN : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin : output_c
      busy_o    = (state_q == S_RUN);
      done_o    = (state_q == S_DONE);
      dbg_state = state_q;
   end

   assign bus.busy    = busy_o;
   assign bus.done    = done_o;
   assign bus.product = product_q;

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin : datapath_c
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      if (accept) begin
         mcand_d  = {{WIDTH{1'b0}}, a_mag};
         mplier_d = b_mag;
         acc_d    = '0;
         neg_d    = neg_cap;
         cnt_d    = '0;
      end else if (state_q == S_RUN) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_shift;
         cnt_d    = cnt_q + CW'(1);
         if (last_iter) begin
            // Magnitude product never exceeds 2^(PW-2) for signed operands,
            // so the negation below cannot overflow.
            product_d = neg_q ? -acc_next : acc_next;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin : datapath_r
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

endmodule : seq_mult

// File: tb/tb_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_mult
// Self-checking bench for seq_mult with WIDTH=8. A behavioural model computes
// each product with plain signed/unsigned arithmetic and a countdown for the
// latency; a compare process checks busy/done/product every falling edge.
// Directed operations additionally pin products and latencies to literals.
// Define SEQ_MULT_EARLY_DONE_EN for both bench and RTL to cover early done.
// -----------------------------------------------------------------------------
module tb_seq_mult;

   localparam int W = 8;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   seq_mult_if #(.WIDTH(W)) bus ();

   seq_mult #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference arithmetic
   // ---------------------------------------------------------------------------
   function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      logic [2*W-1:0]        ua;
      logic [2*W-1:0]        ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      if (s) return sa * sb;
      return ua * ub;
   endfunction

   // Cycles from the accepting edge to the cycle showing done.
   function automatic int lat_of(input logic [W-1:0] b, input logic s);
      int k;
      logic [W-1:0] bm;
      bm = (s && b[W-1]) ? -b : b;
      k = W;
`ifdef SEQ_MULT_EARLY_DONE_EN
      k = 1;
      for (int i = 0; i < W; i++) begin
         if (bm[i]) k = i + 1;
      end
`endif
      return k;
   endfunction

   // ---------------------------------------------------------------------------
   // Behavioural model and scoreboard
   // ---------------------------------------------------------------------------
   logic [2*W-1:0] exp_q[$];
   int             m_rem = 0;
   bit             m_done = 1'b0;
   logic [2*W-1:0] m_product = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem     = 0;
         m_done    = 1'b0;
         m_product = '0;
         exp_q.delete();
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_done = 1'b1;
               if (exp_q.size() > 0) m_product = exp_q.pop_front();
            end
         end else if (bus.start) begin
            exp_q.push_back(ref_mult(bus.a, bus.b, bus.is_signed));
            m_rem = lat_of(bus.b, bus.is_signed);
         end
      end
   end

   // Compare process: outputs sampled on the falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("busy", 32'(bus.busy), 32'(m_rem > 0));
         check("done", 32'(bus.done), 32'(m_done));
         check("product", 32'(bus.product), 32'(m_product));
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // Issue one operation, wait (bounded) for done, then check latency, busy
   // length and product against literals. Returns in the DONE cycle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] exp_p, input int exp_lat,
                        input bit now, input bit disturb, input string name);
      int cyc;
      int busy_cnt;
      if (!now) @(negedge clk);
      bus.start     = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.is_signed = s;
      @(negedge clk);
      bus.start = 1'b0;
      cyc       = 0;
      busy_cnt  = 0;
      while (!bus.done && cyc < 40) begin
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         cyc++;
         if (disturb) begin
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            bus.is_signed = 1'($urandom);
            bus.start     = (cyc == 3);
         end
      end
      bus.start = 1'b0;
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
      check({name, " product"}, 32'(bus.product), 32'(exp_p));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      idle(3);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset product", 32'(bus.product), 32'd0);
      rst_n    = 1'b1;
      check_en = 1'b1;
      idle(2);

      // Unsigned full-scale, then confirm product holds.
      do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, W, 1'b0, 1'b0, "u255x255");
      idle(3);
      check("product hold", 32'(bus.product), 32'hFE01);

      // Signed corner cases and unsigned 0x80 squared.
      do_op(8'h80, 8'h80, 1'b1, 16'h4000, W, 1'b0, 1'b0, "s-128x-128");
      do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, lat_of(8'h05, 1'b1), 1'b0, 1'b0, "s-3x5");
      do_op(8'h7F, 8'hFF, 1'b1, 16'hFF81, lat_of(8'hFF, 1'b1), 1'b0, 1'b0, "s127x-1");
      do_op(8'h80, 8'h80, 1'b0, 16'h4000, W, 1'b0, 1'b0, "u128x128");

      // Start pulse and operand churn mid-run are ignored.
      do_op(8'h0D, 8'h0B, 1'b0, 16'h008F, lat_of(8'h0B, 1'b0), 1'b0, 1'b1, "ignored start");

      // Back-to-back: second op issued in the DONE cycle of the first.
      do_op(8'h09, 8'h09, 1'b0, 16'h0051, W, 1'b0, 1'b0, "b2b first");
      do_op(8'h06, 8'h07, 1'b0, 16'h002A, lat_of(8'h07, 1'b0), 1'b1, 1'b0, "b2b second");

`ifdef SEQ_MULT_EARLY_DONE_EN
      do_op(8'h07, 8'h01, 1'b0, 16'h0007, 1, 1'b0, 1'b0, "early 7x1");
      do_op(8'h03, 8'h00, 1'b0, 16'h0000, 1, 1'b0, 1'b0, "early 3x0");
      do_op(8'h02, 8'hC0, 1'b1, 16'hFF80, 7, 1'b0, 1'b0, "early 2x-64");
`endif

      // Asynchronous reset in the middle of a run.
      idle(1);
      bus.start     = 1'b1;
      bus.a         = 8'hFF;
      bus.b         = 8'hFF;
      bus.is_signed = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      idle(3);
      #1 rst_n = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort product", 32'(bus.product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("no done after abort", 32'(bus.done), 32'd0);
      end

      // Randomised traffic, including long stretches of start held high.
      for (int blk = 0; blk < 12; blk++) begin
         int pct;
         pct = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 50 : 10);
         for (int c = 0; c < 200; c++) begin
            bus.start     = ($urandom_range(0, 99) < pct);
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            bus.is_signed = 1'($urandom);
            @(negedge clk);
         end
      end
      bus.start = 1'b0;
      idle(20);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_seq_mult

// File: doc/seq_mult.md
# seq_mult

Iterative shift-and-add multiplier, the clocked successor to our combinational 8-bit multiplier. It is parametrised in operand width, supports per-operation signed or unsigned mode, and exposes a start/done handshake. It retires one multiplier bit per clock, trading latency for a single adder. It sits behind the lab datapath and the display controller, which issue one multiply at a time.

## Interface
- `WIDTH`, default 8: operand width in bits, minimum 2. The product is `2*WIDTH` bits.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a multiply. Sampled only when the unit is not busy.
- `is_signed`  in  1  operand mode, sampled together with `start`. 1 selects two's-complement, 0 selects unsigned.
- `a`  in  WIDTH  multiplicand, sampled with `start`.
- `b`  in  WIDTH  multiplier, sampled with `start`.
- `busy`  out  1  high while the FSM is in RUN.
- `done`  out  1  one-cycle pulse when `product` is updated.
- `product`  out  2*WIDTH  result. Holds its value until the next `done`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `product`=0. All internal registers are cleared.
- Start acceptance:
  - `start` is accepted when the FSM is in IDLE or DONE (back-to-back issue is allowed). On acceptance the FSM moves to RUN.
  - `start` is ignored in RUN. While in RUN, changes on `a`, `b` and `is_signed` have no effect.
- Operand capture at acceptance:
  - Signed mode: store the magnitudes `|a|` and `|b|` as unsigned WIDTH-bit values (the most negative value maps to 2^(WIDTH-1)), and set `neg = a[MSB] ^ b[MSB]`.
  - Unsigned mode: store the operands unchanged and set `neg` = 0.
  - The multiplicand register is 2*WIDTH bits wide and is zero-extended. The accumulator is cleared.
- Each RUN cycle:
  - If the multiplier LSB is 1, the accumulator takes accumulator + multiplicand, truncated to 2*WIDTH bits.
  - The multiplicand shifts left by 1. The multiplier shifts right by 1 with a 0 fill.
  - An iteration counter increments.
- Final iteration:
  - `product` receives `neg ? -acc_next : acc_next`, computed as a 2*WIDTH two's-complement value.
  - The FSM moves to DONE.
- DONE lasts exactly one cycle with `done`=1. The FSM then returns to IDLE, unless `start` is accepted in that cycle.
- Overflow cannot occur. The magnitude product is at most (2^WIDTH−1)^2 or 2^(2*WIDTH−2), and both fit in 2*WIDTH bits.

## Timing
- Define the accepting edge as E0.
- `busy` is 1 from after E0 through the final iteration edge.
- Latency:
  - Without early termination, the final iteration is edge E_WIDTH. `done` and the new `product` are visible in the cycle after E_WIDTH, i.e. WIDTH cycles after the start edge.
  - With early termination enabled, latency is k cycles (see Configuration).
- Throughput: a new operation can be accepted during the DONE cycle, giving one result per WIDTH+1 cycles at most.
- Asynchronous reset mid-RUN: the FSM goes to IDLE immediately and outputs return to their reset values. No `done` is produced for the aborted operation.
- `start` held high continuously restarts the unit in every DONE cycle, using the operands present in that cycle.

## Configuration
- `SEQ_MULT_EARLY_DONE_EN` defined:
  - The last iteration is the one in which the shifted multiplier becomes zero.
  - Latency k = index of the highest set bit of the captured multiplier + 1, with a minimum of 1. A captured multiplier of 0 gives k=1 and a result of 0.
  - Results are identical to the undefined case.
- Macro undefined: every operation takes exactly WIDTH RUN cycles regardless of operand values.

## Test plan
All scenarios use WIDTH=8.
- Unsigned 255×255 → `product`=0xFE01. `done` pulses 8 cycles after the start edge, `busy` is high for 8 cycles, and `product` holds afterwards.
- Signed: −128×−128 → 0x4000; −3×5 → 0xFFF1; 127×−1 → 0xFF81. Unsigned 0x80×0x80 → 0x4000.
- Pulse `start` with new `a`/`b` at RUN cycle 3, and change the operands mid-operation → ignored. The original result is produced on schedule.
- Back-to-back: assert `start` in the DONE cycle with 6×7 → second `done` arrives 8 cycles later with 0x002A and no idle cycle in between.
- Assert `rst_n`=0 at RUN cycle 4 → `busy`, `done` and `product` go to 0 immediately. No `done` follows after release.
- With `SEQ_MULT_EARLY_DONE_EN`:
  - 7×1 → `done` 1 cycle after start, `product` 0x0007.
  - 3×0 → `done` 1 cycle after start, `product` 0.
  - Signed 2×−64 → k=7, `product` 0xFF80.
